// File: rtl/scoreboard_cmp.sv
// Scoreboard for the up/down/load counter family: reference model, latency-matched
// expected outputs, registered compare, saturating error count and first-error capture.
module scoreboard_cmp #(
  parameter int W       = 32,
  parameter int STEP    = 3,
  parameter int LATENCY = 1,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    modo,
  input  logic [W-1:0]  D,
  input  logic [W-1:0]  dut_q,
  input  logic          dut_rco,
  output logic [W-1:0]  exp_q,
  output logic          exp_rco,
  output logic          mismatch,
  output logic [CW-1:0] err_count,
  output logic          first_err,
  output logic [CW-1:0] first_cycle,
  output logic [W-1:0]  first_exp_q,
  output logic [W-1:0]  first_dut_q
);

  localparam logic [W-1:0]  STEP_W  = W'(STEP);
  localparam logic [W-1:0]  Q_MAX   = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Returns {rco, q} for one enabled model step; all arithmetic wraps mod 2^W.
  function automatic logic [W:0] model_next(input logic [1:0] m, input logic [W-1:0] q,
                                            input logic [W-1:0] d);
    logic [W:0] nxt;
    case (m)
      2'b00:   nxt = (q == Q_MAX) ? {1'b1, {W{1'b0}}} : {1'b0, q + 1'b1};
      2'b01:   nxt = (q == '0) ? {1'b1, Q_MAX} : {1'b0, q - 1'b1};
      2'b10:   nxt = {(q < STEP_W), q - STEP_W};
      default: nxt = {1'b1, d};
    endcase
    return nxt;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [W-1:0]  q_p0;
  logic          rco_p0;
  logic          vld_p0;
  logic          chk_valid;
  logic          fail;
  logic [CW-1:0] cyc_cnt;

  // Stage p0: reference model register; vld_p0 marks a value produced by an enabled step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_p0   <= '0;
      rco_p0 <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= enable;
      if (enable) {rco_p0, q_p0} <= model_next(modo, q_p0, D);
    end
  end

  generate
    if (LATENCY == 0) begin : g_nodly
      assign exp_q     = q_p0;
      assign exp_rco   = rco_p0;
      assign chk_valid = vld_p0;
    end else begin : g_pipe
      logic [W-1:0] q_pipe   [LATENCY];
      logic         rco_pipe [LATENCY];
      logic         vld_pipe [LATENCY];

      // Alignment pipe: shifts every cycle so model output tracks the DUT's fixed delay.
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < LATENCY; i++) begin
            q_pipe[i]   <= '0;
            rco_pipe[i] <= 1'b0;
            vld_pipe[i] <= 1'b0;
          end
        end else begin
          q_pipe[0]   <= q_p0;
          rco_pipe[0] <= rco_p0;
          vld_pipe[0] <= vld_p0;
          for (int i = 1; i < LATENCY; i++) begin
            q_pipe[i]   <= q_pipe[i-1];
            rco_pipe[i] <= rco_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
          end
        end
      end

      assign exp_q     = q_pipe[LATENCY-1];
      assign exp_rco   = rco_pipe[LATENCY-1];
      assign chk_valid = vld_pipe[LATENCY-1];
    end
  endgenerate

  assign fail = chk_valid && ((dut_q != exp_q) || (dut_rco != exp_rco));

  // Compare stage: registered result, counters and first-error snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mismatch    <= 1'b0;
      err_count   <= '0;
      first_err   <= 1'b0;
      first_cycle <= '0;
      first_exp_q <= '0;
      first_dut_q <= '0;
      cyc_cnt     <= '0;
    end else begin
      mismatch <= fail;
      cyc_cnt  <= sat_inc(cyc_cnt);
      if (fail) err_count <= sat_inc(err_count);
      if (fail && !first_err) begin
        first_err   <= 1'b1;
        first_cycle <= cyc_cnt;
        first_exp_q <= exp_q;
        first_dut_q <= dut_q;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_cmp.sv
// Randomised self-checking bench for scoreboard_cmp against a queue-based reference.
module tb_scoreboard_cmp;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [1:0]  modo;
  logic [31:0] D, dut_q, dut_q_s;
  logic        dut_rco, dut_rco_s;
  logic [31:0] exp_q, exp_q_s, first_exp_q, first_dut_q, fe_s, fd_s;
  logic        exp_rco, exp_rco_s, mismatch, mismatch_s, first_err, ferr_s;
  logic [15:0] err_count, first_cycle;
  logic [3:0]  err_s, fc_s;

  always #5 clk = ~clk;

  scoreboard_cmp #(.W(32), .STEP(3), .LATENCY(L), .CW(16)) u_main (
    .clk(clk), .reset(reset), .enable(enable), .modo(modo), .D(D),
    .dut_q(dut_q), .dut_rco(dut_rco), .exp_q(exp_q), .exp_rco(exp_rco),
    .mismatch(mismatch), .err_count(err_count), .first_err(first_err),
    .first_cycle(first_cycle), .first_exp_q(first_exp_q), .first_dut_q(first_dut_q));

  scoreboard_cmp #(.W(32), .STEP(3), .LATENCY(L), .CW(4)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .modo(modo), .D(D),
    .dut_q(dut_q_s), .dut_rco(dut_rco_s), .exp_q(exp_q_s), .exp_rco(exp_rco_s),
    .mismatch(mismatch_s), .err_count(err_s), .first_err(ferr_s),
    .first_cycle(fc_s), .first_exp_q(fe_s), .first_dut_q(fd_s));

  typedef struct packed { logic [31:0] q; logic rco; logic v; } ent_t;

  int checks = 0;
  int failures = 0;

  // Reference state
  ent_t        dly[$];
  logic [31:0] mq;
  logic        mrco;
  logic [31:0] e_q, e_fexp, e_fdut;
  logic        e_rco, e_mis, e_mis_s, e_ferr, stuck;
  int          e_err, e_err_s, e_fcyc, cyc;

  task automatic model_clear();
    mq = '0; mrco = 1'b0; cyc = 0;
    e_q = '0; e_rco = 1'b0; e_mis = 1'b0; e_mis_s = 1'b0; e_ferr = 1'b0;
    e_err = 0; e_err_s = 0; e_fcyc = 0; e_fexp = '0; e_fdut = '0;
    dly.delete();
    for (int i = 0; i <= L; i++) dly.push_back('0);
  endtask

  task automatic step(input bit rn, input bit en, input logic [1:0] m,
                      input logic [31:0] d, input logic [31:0] flt);
    ent_t cur;
    bit   fail, fail_s;
    reset = rn; enable = en; modo = m; D = d;
    dut_q = e_q ^ flt; dut_rco = e_rco;
    dut_q_s = stuck ? 32'h0 : e_q; dut_rco_s = stuck ? 1'b0 : e_rco;
    @(posedge clk); #1;
    if (!rn) begin
      model_clear();
    end else begin
      cur = dly[0];
      fail   = cur.v && ((dut_q != cur.q) || (dut_rco != cur.rco));
      fail_s = cur.v && ((dut_q_s != cur.q) || (dut_rco_s != cur.rco));
      e_mis = fail; e_mis_s = fail_s;
      if (fail && e_err < 65535) e_err++;
      if (fail_s && e_err_s < 15) e_err_s++;
      if (fail && !e_ferr) begin
        e_ferr = 1'b1; e_fcyc = cyc; e_fexp = cur.q; e_fdut = dut_q;
      end
      if (cyc < 65535) cyc++;
      if (en) begin
        case (m)
          2'b00: begin mrco = (mq == 32'hFFFF_FFFF); mq = mq + 32'd1; end
          2'b01: begin mrco = (mq == 32'd0); mq = mq - 32'd1; end
          2'b10: begin mrco = (mq < 32'd3); mq = mq - 32'd3; end
          default: begin mrco = 1'b1; mq = d; end
        endcase
      end
      dly.push_back('{q: mq, rco: mrco, v: en});
      void'(dly.pop_front());
      e_q = dly[0].q; e_rco = dly[0].rco;
    end
  endtask

  task automatic test_reset();
    step(0, 1, 2'b00, 32'h0, 0);
    step(0, 1, 2'b11, 32'h1234, 0);
    checks++; if (exp_q !== 32'h0 || exp_rco !== 1'b0) begin failures++;
      $display("FAIL reset_exp got q=%h rco=%b want 0/0", exp_q, exp_rco); end
    checks++; if (mismatch !== 1'b0 || err_count !== 16'd0 || first_err !== 1'b0) begin failures++;
      $display("FAIL reset_err got mis=%b err=%0d ferr=%b want 0", mismatch, err_count, first_err); end
    checks++; if (first_cycle !== 16'd0 || first_exp_q !== 32'h0 || first_dut_q !== 32'h0) begin failures++;
      $display("FAIL reset_first got %0d %h %h want 0", first_cycle, first_exp_q, first_dut_q); end
    checks++; if (err_s !== 4'd0 || mismatch_s !== 1'b0) begin failures++;
      $display("FAIL reset_sat got err=%0d mis=%b want 0", err_s, mismatch_s); end
  endtask

  task automatic test_count_wrap();
    logic [31:0] wq [4];
    logic        wr [4];
    wq[0] = 32'hFFFF_FFFE; wq[1] = 32'hFFFF_FFFF; wq[2] = 32'h0; wq[3] = 32'h1;
    wr[0] = 1'b1; wr[1] = 1'b0; wr[2] = 1'b1; wr[3] = 1'b0;
    step(1, 1, 2'b11, 32'hFFFF_FFFE, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, (i < 3), 2'b00, 32'h0, 0);
      checks++; if (exp_q !== wq[i] || exp_rco !== wr[i]) begin failures++;
        $display("FAIL wrap_%0d got q=%h rco=%b want q=%h rco=%b", i, exp_q, exp_rco, wq[i], wr[i]); end
    end
    checks++; if (err_count !== 16'd0) begin failures++;
      $display("FAIL wrap_err got %0d want 0", err_count); end
  endtask

  task automatic test_step_down();
    logic [1:0]  sm [7];
    logic [31:0] sd [7];
    logic [31:0] wq [6];
    logic        wr [6];
    sm[0] = 2'b11; sm[1] = 2'b10; sm[2] = 2'b10; sm[3] = 2'b11; sm[4] = 2'b01; sm[5] = 2'b11; sm[6] = 2'b11;
    sd[0] = 32'd2; sd[1] = 0; sd[2] = 0; sd[3] = 32'd0; sd[4] = 0; sd[5] = 32'd5; sd[6] = 32'd5;
    wq[0] = 32'd2; wq[1] = 32'hFFFF_FFFF; wq[2] = 32'hFFFF_FFFC; wq[3] = 32'h0; wq[4] = 32'hFFFF_FFFF; wq[5] = 32'd5;
    wr[0] = 1'b1;  wr[1] = 1'b1;          wr[2] = 1'b0;          wr[3] = 1'b1;  wr[4] = 1'b1;          wr[5] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1, 1, sm[i], sd[i], 0);
      if (i > 0) begin
        checks++; if (exp_q !== wq[i-1] || exp_rco !== wr[i-1]) begin failures++;
          $display("FAIL down_%0d got q=%h rco=%b want q=%h rco=%b", i, exp_q, exp_rco, wq[i-1], wr[i-1]); end
      end
    end
    step(1, 0, 2'b00, 0, 0);
    checks++; if (exp_q !== 32'd5 || exp_rco !== 1'b1) begin failures++;
      $display("FAIL reload_same got q=%h rco=%b want 5/1", exp_q, exp_rco); end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    logic        held_r;
    for (int i = 0; i < 6; i++) step(1, 1, 2'($urandom_range(0, 3)), $urandom, 0);
    step(1, 0, 2'b00, 0, 0);
    held = exp_q; held_r = exp_rco;
    checks++; if (exp_q !== e_q) begin failures++;
      $display("FAIL hold_start got %h want %h", exp_q, e_q); end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 2'($urandom_range(0, 3)), $urandom, 0);
      checks++; if (exp_q !== held || exp_rco !== held_r || mismatch !== 1'b0) begin failures++;
        $display("FAIL hold_%0d got q=%h rco=%b mis=%b want q=%h rco=%b mis=0",
                 i, exp_q, exp_rco, mismatch, held, held_r); end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: d = 32'hFFFF_FFFF - $urandom_range(0, 2);
        1: d = $urandom_range(0, 4);
        default: d = $urandom;
      endcase
      step(1, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), d, 0);
      checks++; if (exp_q !== e_q || exp_rco !== e_rco) begin failures++;
        $display("FAIL rand_exp_%0d got q=%h rco=%b want q=%h rco=%b", i, exp_q, exp_rco, e_q, e_rco); end
      checks++; if (mismatch !== e_mis || err_count !== 16'(e_err)) begin failures++;
        $display("FAIL rand_err_%0d got mis=%b err=%0d want mis=%b err=%0d", i, mismatch, err_count, e_mis, e_err); end
    end
  endtask

  task automatic test_fault();
    logic [31:0] mask, fexp;
    mask = 32'd1 << $urandom_range(0, 31);
    step(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 2'($urandom_range(0, 3)), $urandom, (i == 10 || i == 13) ? mask : 32'h0);
      if (i == 10) begin
        checks++; if (mismatch !== 1'b1 || err_count !== 16'd1) begin failures++;
          $display("FAIL fault_pulse got mis=%b err=%0d want 1/1", mismatch, err_count); end
        checks++; if (first_err !== 1'b1 || first_cycle !== 16'd10 || first_cycle !== 16'(e_fcyc)) begin failures++;
          $display("FAIL fault_cycle got ferr=%b cyc=%0d want 1/10", first_err, first_cycle); end
        checks++; if ((first_exp_q ^ first_dut_q) !== mask || first_exp_q !== e_fexp) begin failures++;
          $display("FAIL fault_cap got exp=%h dut=%h want exp=%h dut=%h", first_exp_q, first_dut_q, e_fexp, e_fdut); end
        fexp = first_exp_q;
      end
      if (i == 11) begin
        checks++; if (mismatch !== 1'b0) begin failures++;
          $display("FAIL fault_onecycle got mis=%b want 0", mismatch); end
      end
    end
    checks++; if (err_count !== 16'd2 || first_cycle !== 16'd10 || first_exp_q !== fexp) begin failures++;
      $display("FAIL fault_frozen got err=%0d cyc=%0d exp=%h want 2/10/%h", err_count, first_cycle, first_exp_q, fexp); end
  endtask

  task automatic test_saturate();
    step(0, 0, 2'b00, 0, 0);
    stuck = 1'b1;
    step(1, 1, 2'b11, 32'd100, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 2'b00, 0, 0);
      checks++; if (err_s !== 4'(e_err_s) || mismatch_s !== e_mis_s) begin failures++;
        $display("FAIL sat_%0d got err=%0d mis=%b want err=%0d mis=%b", i, err_s, mismatch_s, e_err_s, e_mis_s); end
    end
    checks++; if (err_s !== 4'd15 || ferr_s !== 1'b1) begin failures++;
      $display("FAIL sat_final got err=%0d ferr=%b want 15/1", err_s, ferr_s); end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 1, 2'b00, 0, 32'h10);
    step(0, 1, 2'b00, 0, 0);
    checks++; if (exp_q !== 0 || exp_rco !== 0 || mismatch !== 0 || err_count !== 0 || first_err !== 0 || err_s !== 0) begin
      failures++;
      $display("FAIL midreset got q=%h rco=%b mis=%b err=%0d ferr=%b errs=%0d want 0",
               exp_q, exp_rco, mismatch, err_count, first_err, err_s); end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'b00, 0, 32'hA5);
      checks++; if (mismatch !== ((i == 2) ? 1'b1 : 1'b0) || mismatch !== e_mis) begin failures++;
        $display("FAIL postreset_%0d got mis=%b want %b", i, mismatch, (i == 2)); end
    end
  endtask

  initial begin
    stuck = 1'b0;
    model_clear();
    test_reset();
    test_count_wrap();
    test_step_down();
    test_hold();
    test_random();
    test_fault();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
